// File: rtl/opcode_seg_display.sv
// Shows the button-encoder opcode on the Nexys4 8-digit display as "OP", blank, hex, binary.
// Flags each opcode change with a one-cycle pulse and a timed decimal-point flash on the hex digit.
module opcode_seg_display #(
    parameter int unsigned REFRESH_DIV  = 12500,
    parameter int unsigned FLASH_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:3] opcode,
    output logic [7:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       opcode_changed
);

    localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned FW = $clog2(FLASH_CYCLES + 1);

    localparam logic [6:0] GLYPH_O     = 7'b1000000;
    localparam logic [6:0] GLYPH_P     = 7'b0001100;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    logic [RW-1:0] refresh_cnt;
    logic [2:0]    digit_idx;
    logic [0:3]    opcode_q;
    logic [0:3]    opcode_prev;
    logic [FW-1:0] flash_cnt;
    logic          change;
    logic          wrap;
    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic          dp_next;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign change = (opcode_q != opcode_prev);
    assign wrap   = (refresh_cnt == RW'(REFRESH_DIV - 1));

    // digit_idx names the slot that the next wrap will light.
    always_comb begin
        nibble  = '0;
        glyph   = GLYPH_BLANK;
        dp_next = 1'b1;
        case (digit_idx)
            3'd7: glyph = GLYPH_O;
            3'd6: glyph = GLYPH_P;
            3'd5: glyph = GLYPH_BLANK;
            3'd4: begin
                nibble  = opcode_q;
                glyph   = hex_glyph(nibble);
                dp_next = (flash_cnt == '0);
            end
            default: begin
                // slot 3 carries opcode_q[0] (MSB) down to slot 0 carrying opcode_q[3]
                nibble = {3'b000, opcode_q[2'd3 - digit_idx[1:0]]};
                glyph  = hex_glyph(nibble);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt    <= '0;
            digit_idx      <= '0;
            opcode_q       <= '0;
            opcode_prev    <= '0;
            flash_cnt      <= '0;
            opcode_changed <= 1'b0;
            AN             <= '1;
            SEG            <= '1;
            DP             <= 1'b1;
        end else begin
            opcode_q       <= opcode;
            opcode_prev    <= opcode_q;
            opcode_changed <= change;

            if (change)
                flash_cnt <= FW'(FLASH_CYCLES);
            else if (flash_cnt != '0)
                flash_cnt <= flash_cnt - 1'b1;

            if (wrap) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 1'b1;
                AN          <= ~(8'b1 << digit_idx);
                SEG         <= glyph;
                DP          <= dp_next;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_opcode_seg_display.sv
// Scoreboard bench for opcode_seg_display: a cycle-numbered reference model predicts display
// updates and change pulses; a monitor pops and compares them as the DUT presents them.
module tb_opcode_seg_display;

    localparam int unsigned R = 4;
    localparam int unsigned F = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:3] opcode = '0;
    logic [7:0] AN;
    logic [6:0] SEG;
    logic       DP;
    logic       opcode_changed;

    opcode_seg_display #(.REFRESH_DIV(R), .FLASH_CYCLES(F)) dut (
        .clk(clk),
        .rst(rst),
        .opcode(opcode),
        .AN(AN),
        .SEG(SEG),
        .DP(DP),
        .opcode_changed(opcode_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } frame_t;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    frame_t     wrap_q[$];
    int         pulse_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         done = 1'b0;

    // reference model state: edges since reset release, opcode_q history, change-detect edges
    int         n = 0;
    int         qh1 = 0;
    int         qh2 = 0;
    int         detects[$];
    logic [0:3] cur = '0;

    logic [7:0] last_an = 8'hFF;
    logic [6:0] last_seg = 7'h7F;
    logic       last_dp = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] digit_glyph(input int idx, input int v);
        case (idx)
            7:       return 7'b1000000;
            6:       return 7'b0001100;
            5:       return 7'b1111111;
            4:       return HEX[v];
            default: return HEX[(v >> idx) & 1];
        endcase
    endfunction

    // Drive inputs for the coming posedge and predict what that edge produces.
    task automatic step(input logic r, input logic [0:3] op);
        frame_t e;
        int     idx;
        bit     fl;
        @(negedge clk);
        rst    = r;
        opcode = op;
        if (r) begin
            n   = 0;
            qh1 = 0;
            qh2 = 0;
            detects.delete();
        end else begin
            n++;
            if (qh1 != qh2) begin
                pulse_q.push_back(cyc + 1);
                detects.push_back(n);
            end
            while (detects.size() > 0 && n - detects[0] > int'(F)) void'(detects.pop_front());
            if (n % R == 0) begin
                idx = (n / R - 1) % 8;
                fl  = 1'b0;
                foreach (detects[i])
                    if (n - detects[i] >= 1 && n - detects[i] <= int'(F)) fl = 1'b1;
                e.cyc = cyc + 1;
                e.an  = ~(8'd1 << idx);
                e.seg = digit_glyph(idx, qh1);
                e.dp  = !(idx == 4 && fl);
                wrap_q.push_back(e);
            end
            qh2 = qh1;
            qh1 = int'(op);
        end
    endtask

    // Monitor: reacts to display updates and change pulses.
    initial begin
        logic   rs;
        frame_t e;
        int     pc;
        forever begin
            @(posedge clk);
            rs = rst;
            #1;
            if (done) break;
            if (rs) begin
                check("reset AN", AN, 8'hFF);
                check("reset SEG", SEG, 7'h7F);
                check("reset DP", DP, 1'b1);
                check("reset pulse", opcode_changed, 1'b0);
                last_an  = 8'hFF;
                last_seg = 7'h7F;
                last_dp  = 1'b1;
            end else begin
                if (AN != last_an) begin
                    if (wrap_q.size() == 0) begin
                        check("unexpected AN update", AN, last_an);
                    end else begin
                        e = wrap_q.pop_front();
                        check("update cycle", cyc, e.cyc);
                        check("AN", AN, e.an);
                        check("SEG", SEG, e.seg);
                        check("DP", DP, e.dp);
                    end
                end else begin
                    check("SEG hold", SEG, last_seg);
                    check("DP hold", DP, last_dp);
                end
                while (wrap_q.size() > 0 && wrap_q[0].cyc <= cyc) begin
                    e = wrap_q.pop_front();
                    check("missed update AN", AN, e.an);
                end
                last_an  = AN;
                last_seg = SEG;
                last_dp  = DP;

                if (opcode_changed) begin
                    if (pulse_q.size() == 0) begin
                        check("unexpected opcode_changed", opcode_changed, 1'b0);
                    end else begin
                        pc = pulse_q.pop_front();
                        check("pulse cycle", cyc, pc);
                    end
                end
                while (pulse_q.size() > 0 && pulse_q[0] <= cyc) begin
                    void'(pulse_q.pop_front());
                    check("missed opcode_changed", opcode_changed, 1'b1);
                end
            end
        end
    end

    initial begin
        bit found;

        repeat (3) step(1'b1, 4'b0000);
        repeat (40) step(1'b0, 4'b0000);

        cur = 4'b1010;
        repeat (50) step(1'b0, cur);

        // retrigger: change, then two more changes mid-flash
        cur = 4'b0101;
        repeat (20) step(1'b0, cur);
        cur = 4'b0011;
        repeat (2) step(1'b0, cur);
        cur = 4'b1010;
        repeat (80) step(1'b0, cur);

        // reset while the hex flash is live and the scan sits on AN=BF
        cur = 4'b0110;
        step(1'b0, cur);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step(1'b0, cur);
            if (AN == 8'hBF) found = 1'b1;
        end
        check("reach AN=BF", found, 1'b1);
        step(1'b1, cur);
        repeat (20) step(1'b0, cur);

        for (int v = 0; v < 16; v++) repeat (34) step(1'b0, 4'(v));

        repeat (400) begin
            if ($urandom_range(7) == 0) cur = 4'($urandom_range(15));
            step($urandom_range(63) == 0, cur);
        end

        repeat (2) step(1'b1, cur);
        done = 1'b1;
        @(posedge clk);
        #2;
        check("pending updates", wrap_q.size(), 0);
        check("pending pulses", pulse_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
